// File: rtl/lstm_pkg.sv
// Shared types for the encoder LSTM sequencer: fixed-point word/vector types and FSM states.
package lstm_pkg;

    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned FRACT_WIDTH = 24;
    localparam int unsigned HIDDEN_SIZE = 10;

    typedef logic signed [DATA_WIDTH-1:0] fxp_t;
    typedef fxp_t fxp_vec_t [HIDDEN_SIZE];

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLaunch,
        StWait,
        StCapture,
        StDrain,
        StResult
    } seq_state_t;

endpackage

// File: rtl/lstm_state_bank.sv
// Recurrent h/c state registers fed back to the LSTM cell; clear wins over load.
module lstm_state_bank
    import lstm_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              load,
    input  logic [HIDDEN_SIZE*DATA_WIDTH-1:0] h_in,
    input  logic [HIDDEN_SIZE*DATA_WIDTH-1:0] c_in,
    output logic [HIDDEN_SIZE*DATA_WIDTH-1:0] h,
    output logic [HIDDEN_SIZE*DATA_WIDTH-1:0] c
);

    fxp_vec_t h_q;
    fxp_vec_t c_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HIDDEN_SIZE; i++) begin
                h_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < HIDDEN_SIZE; i++) begin
                h_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < HIDDEN_SIZE; i++) begin
                h_q[i] <= h_in[i*DATA_WIDTH +: DATA_WIDTH];
                c_q[i] <= c_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    for (genvar g = 0; g < HIDDEN_SIZE; g++) begin : g_flat
        assign h[g*DATA_WIDTH +: DATA_WIDTH] = h_q[g];
        assign c[g*DATA_WIDTH +: DATA_WIDTH] = c_q[g];
    end

endmodule

// File: rtl/lstm_seq_ctrl.sv
// Sequencer for the encoder LSTM cell: one cell step per accepted sample, h/c fed back,
// final hidden vector and sequence length returned with per-sequence error flags.
module lstm_seq_ctrl
    import lstm_pkg::*;
#(
    parameter  int unsigned MAX_SEQ_LEN    = 256,
    parameter  int unsigned TIMEOUT_CYCLES = 10000,
    localparam int unsigned VEC_W          = HIDDEN_SIZE * DATA_WIDTH,
    localparam int unsigned LEN_W          = $clog2(MAX_SEQ_LEN + 1),
    localparam int unsigned WD_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  x_valid,
    output logic                  x_ready,
    input  logic [DATA_WIDTH-1:0] x_data,
    input  logic                  x_last,
    output logic                  cell_start,
    input  logic                  cell_done,
    output logic [DATA_WIDTH-1:0] cell_x,
    output logic [VEC_W-1:0]      cell_h_prev,
    output logic [VEC_W-1:0]      cell_c_prev,
    input  logic [VEC_W-1:0]      cell_h_out,
    input  logic [VEC_W-1:0]      cell_c_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [VEC_W-1:0]      h_final,
    output logic [LEN_W-1:0]      out_len,
    output logic                  busy,
    output logic                  err_timeout,
    output logic                  err_overlen
);

    seq_state_t            state_q, state_d;
    logic [LEN_W-1:0]      step_q, step_d;
    logic [WD_W-1:0]       wdog_q, wdog_d;
    logic [DATA_WIDTH-1:0] x_q, x_d;
    logic                  last_q, last_d;
    logic                  to_q, to_d;
    logic                  ov_q, ov_d;
    logic [VEC_W-1:0]      hfin_q, hfin_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  oval_q, oval_d;
    logic                  armed_q;
    logic                  accept;
    logic                  bank_clear;
    logic                  bank_load;

    lstm_state_bank u_bank (
        .clk   (clk),
        .rst   (rst),
        .clear (bank_clear),
        .load  (bank_load),
        .h_in  (cell_h_out),
        .c_in  (cell_c_out),
        .h     (cell_h_prev),
        .c     (cell_c_prev)
    );

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        wdog_d     = wdog_q;
        x_d        = x_q;
        last_d     = last_q;
        to_d       = to_q;
        ov_d       = ov_q;
        hfin_d     = hfin_q;
        len_d      = len_q;
        oval_d     = oval_q;
        bank_clear = 1'b0;
        bank_load  = 1'b0;
        // armed_q keeps x_ready low while reset is asserted
        x_ready    = armed_q && (state_q == StIdle || state_q == StFetch);
        accept     = x_valid && x_ready;
        // A step abandoned by the watchdog may still hold done; never launch over it
        cell_start = (state_q == StLaunch) && !cell_done;

        unique case (state_q)
            StIdle, StFetch: begin
                if (accept) begin
                    x_d     = x_data;
                    last_d  = x_last;
                    state_d = StLaunch;
                    if (state_q == StIdle) begin
                        bank_clear = 1'b1;
                        step_d     = '0;
                        to_d       = 1'b0;
                        ov_d       = 1'b0;
                    end
                end
            end
            StLaunch: begin
                wdog_d = '0;
                if (!cell_done) state_d = StWait;
            end
            StWait: begin
                if (cell_done) begin
                    state_d = StCapture;
                end else if (wdog_q >= WD_W'(TIMEOUT_CYCLES - 1)) begin
                    wdog_d  = WD_W'(TIMEOUT_CYCLES);
                    to_d    = 1'b1;
                    state_d = StResult;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            StCapture: begin
                bank_load = 1'b1;
                if (step_q != LEN_W'(MAX_SEQ_LEN)) step_d = step_q + 1'b1;
                state_d = StDrain;
            end
            StDrain: begin
                if (!cell_done) begin
                    if (last_q) begin
                        state_d = StResult;
                    end else if (step_q == LEN_W'(MAX_SEQ_LEN)) begin
                        ov_d    = 1'b1;
                        state_d = StResult;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StResult: begin
                if (!oval_q) begin
                    hfin_d = cell_h_prev;
                    len_d  = step_q;
                    oval_d = 1'b1;
                end else if (out_ready) begin
                    oval_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            step_q  <= '0;
            wdog_q  <= '0;
            x_q     <= '0;
            last_q  <= 1'b0;
            to_q    <= 1'b0;
            ov_q    <= 1'b0;
            hfin_q  <= '0;
            len_q   <= '0;
            oval_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            wdog_q  <= wdog_d;
            x_q     <= x_d;
            last_q  <= last_d;
            to_q    <= to_d;
            ov_q    <= ov_d;
            hfin_q  <= hfin_d;
            len_q   <= len_d;
            oval_q  <= oval_d;
            armed_q <= 1'b1;
        end
    end

    assign cell_x      = x_q;
    assign out_valid   = oval_q;
    assign h_final     = hfin_q;
    assign out_len     = len_q;
    assign busy        = (state_q != StIdle);
    assign err_timeout = to_q;
    assign err_overlen = ov_q;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Scoreboard bench for lstm_seq_ctrl: behavioural cell stub, sequence-level reference model,
// launch and result monitors decoupled from stimulus.
module tb_lstm_seq_ctrl;
    import lstm_pkg::*;

    localparam int DW   = DATA_WIDTH;
    localparam int HS   = HIDDEN_SIZE;
    localparam int MAXL = 4;
    localparam int TOC  = 50;
    localparam int LW   = $clog2(MAXL + 1);

    typedef logic [HS*DW-1:0] vec_t;
    typedef struct {
        logic [DW-1:0] x;
        vec_t          h;
        vec_t          c;
        int            lat;
        int            hold;
    } launch_t;
    typedef struct {
        vec_t h;
        int   len;
        bit   to;
        bit   ov;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          x_valid, x_ready, x_last;
    logic [DW-1:0] x_data, cell_x;
    logic          cell_start, cell_done;
    vec_t          cell_h_prev, cell_c_prev, cell_h_out, cell_c_out, h_final;
    logic          out_valid, out_ready, busy, err_timeout, err_overlen;
    logic [LW-1:0] out_len;

    lstm_seq_ctrl #(
        .MAX_SEQ_LEN    (MAXL),
        .TIMEOUT_CYCLES (TOC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .x_valid     (x_valid),
        .x_ready     (x_ready),
        .x_data      (x_data),
        .x_last      (x_last),
        .cell_start  (cell_start),
        .cell_done   (cell_done),
        .cell_x      (cell_x),
        .cell_h_prev (cell_h_prev),
        .cell_c_prev (cell_c_prev),
        .cell_h_out  (cell_h_out),
        .cell_c_out  (cell_c_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .h_final     (h_final),
        .out_len     (out_len),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_overlen (err_overlen)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int launches = 0;
    int accepts  = 0;
    int start_cyc = 0;
    int hold_cfg = -1;
    bit res_active = 1'b0;

    launch_t lq[$];
    res_t    rq[$];
    vec_t    mh, mc;
    int      mlen = 0;
    bit      new_seq = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural LSTM cell stand-in: any deterministic mix of x, h and c will do.
    function automatic void cell_fn(input logic [DW-1:0] x, input vec_t h, input vec_t c,
                                    output vec_t hn, output vec_t cn);
        logic [DW-1:0] hi, ci;
        for (int i = 0; i < HS; i++) begin
            hi = h[i*DW +: DW];
            ci = c[i*DW +: DW];
            hn[i*DW +: DW] = x + {hi[DW-1], hi[DW-1:1]} + ci + DW'(i);
            cn[i*DW +: DW] = (ci ^ x) - hi + DW'(7 * i + 1);
        end
    endfunction

    // Sequence-level reference: what each accepted sample should launch and produce.
    task automatic model_accept(input logic [DW-1:0] x, input bit last, input int lat,
                                input int hold);
        launch_t l;
        res_t    r;
        vec_t    hn, cn;
        if (new_seq) begin
            mh = '0;
            mc = '0;
            mlen = 0;
            new_seq = 1'b0;
        end
        l.x = x; l.h = mh; l.c = mc; l.lat = lat; l.hold = hold;
        lq.push_back(l);
        accepts++;
        if (lat == 0) begin
            r.h = mh; r.len = mlen; r.to = 1'b1; r.ov = 1'b0;
            rq.push_back(r);
            new_seq = 1'b1;
            return;
        end
        cell_fn(x, mh, mc, hn, cn);
        mh = hn;
        mc = cn;
        mlen++;
        if (last || mlen == MAXL) begin
            r.h = mh; r.len = mlen; r.to = 1'b0; r.ov = !last;
            rq.push_back(r);
            new_seq = 1'b1;
        end
    endtask

    task automatic send(input logic [DW-1:0] x, input bit last, input int lat, input int hold,
                        input int gap);
        int t;
        bit ok;
        for (int g = 0; g < gap; g++) begin
            x_data = DW'($urandom);
            @(negedge clk);
        end
        x_valid = 1'b1;
        x_data  = x;
        x_last  = last;
        t = 0;
        ok = 1'b0;
        while (t < 3000) begin
            if (x_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            t++;
        end
        if (!ok) begin
            chk(1'b0, "accept_wait", 512'(t), 512'(0));
            x_valid = 1'b0;
            return;
        end
        model_accept(x, last, lat, hold);
        @(negedge clk);
        x_valid = 1'b0;
        x_last  = 1'b0;
        x_data  = DW'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((rq.size() != 0 || res_active || busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk(1'b0, "idle_wait", 512'(rq.size()), 512'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({x_ready, cell_start, out_valid, busy, err_timeout, err_overlen} == 6'b0,
            {tag, "_ctrl"}, 512'({x_ready, cell_start, out_valid, busy, err_timeout,
            err_overlen}), 512'(0));
        chk(cell_x == '0 && out_len == '0, {tag, "_x_len"}, 512'({cell_x, out_len}), 512'(0));
        chk(cell_h_prev == '0 && cell_c_prev == '0, {tag, "_hc"},
            512'(cell_h_prev | cell_c_prev), 512'(0));
        chk(h_final == '0, {tag, "_h_final"}, 512'(h_final), 512'(0));
    endtask

    // Cell stub plus launch-side scoreboard
    int      cnt = 0, hleft = 0, chold = 0;
    bit      prev_start = 1'b0, done_was;
    logic [DW-1:0] capx;
    vec_t    caph, capc;
    launch_t le;

    initial begin
        cell_done  = 1'b0;
        cell_h_out = '0;
        cell_c_out = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cell_done  = 1'b0;
                cnt        = 0;
                hleft      = 0;
                prev_start = 1'b0;
            end else begin
                done_was = cell_done;
                if (cell_done) begin
                    hleft--;
                    if (hleft <= 0) cell_done = 1'b0;
                end
                if (cell_start) begin
                    if (lq.size() == 0) begin
                        chk(1'b0, "unexpected_launch", 512'(cell_x), 512'(0));
                    end else begin
                        le = lq.pop_front();
                        chk(cell_x == le.x, "launch_x", 512'(cell_x), 512'(le.x));
                        chk(cell_h_prev == le.h, "launch_h_prev", 512'(cell_h_prev), 512'(le.h));
                        chk(cell_c_prev == le.c, "launch_c_prev", 512'(cell_c_prev), 512'(le.c));
                        chk(!done_was && !prev_start, "launch_clean",
                            512'({done_was, prev_start}), 512'(0));
                        cnt   = le.lat;
                        chold = le.hold;
                    end
                    launches++;
                    start_cyc = cyc;
                    capx = cell_x;
                    caph = cell_h_prev;
                    capc = cell_c_prev;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        cell_fn(capx, caph, capc, cell_h_out, cell_c_out);
                        cell_done = 1'b1;
                        hleft     = chold;
                    end
                end
                prev_start = cell_start;
            end
        end
    end

    // Result monitor
    res_t re;
    vec_t snap_h;
    logic [LW-1:0] snap_len;
    int   wait_cnt = 0;
    bit   stable = 1'b1;

    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                res_active = 1'b0;
                out_ready  = 1'b0;
            end else if (!res_active) begin
                if (out_valid) begin
                    res_active = 1'b1;
                    stable     = 1'b1;
                    if (rq.size() == 0) begin
                        chk(1'b0, "unexpected_result", 512'(out_len), 512'(0));
                    end else begin
                        re = rq.pop_front();
                        chk(h_final == re.h, "h_final", 512'(h_final), 512'(re.h));
                        chk(int'(out_len) == re.len, "out_len", 512'(out_len), 512'(re.len));
                        chk(err_timeout == re.to, "err_timeout", 512'(err_timeout), 512'(re.to));
                        chk(err_overlen == re.ov, "err_overlen", 512'(err_overlen), 512'(re.ov));
                    end
                    snap_h    = h_final;
                    snap_len  = out_len;
                    wait_cnt  = (hold_cfg >= 0) ? hold_cfg : int'($urandom_range(0, 3));
                    out_ready = (wait_cnt == 0);
                end
            end else if (out_ready) begin
                chk(stable && !out_valid, "result_hold", 512'({stable, out_valid}), 512'(2));
                res_active = 1'b0;
                out_ready  = 1'b0;
            end else begin
                if (!out_valid || h_final != snap_h || out_len != snap_len || x_ready)
                    stable = 1'b0;
                wait_cnt--;
                if (wait_cnt <= 0) out_ready = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        rst     = 1'b1;
        x_valid = 1'b0;
        x_data  = '0;
        x_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Three-sample sequence with fixed values
        send(32'h0100_0000, 1'b0, 12, 2, 0);
        send(32'h0080_0000, 1'b0, 12, 2, 0);
        send(32'hFF00_0000, 1'b1, 12, 2, 0);
        wait_idle();

        // Consumer stalls 20 cycles; following sequence must start from zero state
        hold_cfg = 20;
        send(32'h0040_0000, 1'b0, 4, 2, 0);
        send(32'h0120_0000, 1'b1, 4, 2, 0);
        wait_idle();
        hold_cfg = -1;
        send(32'h0200_0000, 1'b0, 3, 2, 1);
        send(32'hFFC0_0000, 1'b1, 3, 2, 0);
        wait_idle();

        // Third step never completes: watchdog ends the sequence with two good steps
        send(32'h0011_0000, 1'b0, 5, 2, 0);
        send(32'h0022_0000, 1'b0, 5, 2, 0);
        send(32'h0033_0000, 1'b1, 0, 0, 0);
        begin
            int t = 0;
            while (!err_timeout && t < 300) begin
                @(negedge clk);
                t++;
            end
            chk(err_timeout, "timeout_seen", 512'(err_timeout), 512'(1));
            // flag registers at the end of the 50th WAIT cycle
            chk(cyc - start_cyc == TOC + 1, "timeout_latency", 512'(cyc - start_cyc),
                512'(TOC + 1));
        end
        wait_idle();

        // Six samples without last: forced stop at 4, then a fresh sequence
        for (int i = 0; i < 6; i++) send(DW'($urandom), 1'b0, 3, 2, 0);
        send(DW'($urandom), 1'b1, 3, 2, 0);
        wait_idle();

        // Random traffic, done held 5 cycles
        for (int i = 0; i < 40; i++)
            send(DW'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(1, 8)), 5,
                 int'($urandom_range(0, 3)));
        send(DW'($urandom), 1'b1, 2, 5, 0);
        wait_idle();

        // Reset while waiting on the cell
        send(32'h0300_0000, 1'b0, 30, 2, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        lq.delete();
        rq.delete();
        new_seq = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(32'h0100_0000, 1'b0, 6, 2, 0);
        send(32'h0080_0000, 1'b0, 6, 2, 0);
        send(32'h0040_0000, 1'b1, 6, 2, 0);
        wait_idle();

        chk(launches == accepts, "launch_count", 512'(launches), 512'(accepts));
        chk(lq.size() == 0, "launch_queue_empty", 512'(lq.size()), 512'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
